store_access_ctrl: RTL and testbench
====================================

// Module: store_access_ctrl
// PURPOSE
//  Bit-serial access sequencer for one group of mercury delay-line tanks.
//  Turns word read/write requests into the per-tank clr/in/out strobes and the serial mib bit.
//  Collects the returned mob bits into parallel words.
//  Sits between the order/control unit and the memory store; it drives the store's control inputs.
//  A free-running circulation counter models the common tank phase.
// PARAMETERS
//  NTANKS     4    tanks in the group (t0..t3)
//  WORDS      32   words circulating per tank
//  WORD_BITS  18   bits per word slot (17 data + 1 gap), LSB first on the line
//  TANK_BITS  576  WORDS*WORD_BITS; circulation length in clk cycles
//  ADDR_W     7    clog2(NTANKS)+clog2(WORDS); addr = {tank, word}
// PORTS
//  clk        in   1          system clock, all state on rising edge
//  rst        in   1          asynchronous reset, active-high
//  req_valid  in   1          request present
//  req_ready  out  1          high only in IDLE; transfer on valid&&ready
//  req_write  in   1          1=write, 0=read
//  req_addr   in   ADDR_W     [ADDR_W-1:5]=tank, [4:0]=word
//  req_wdata  in   WORD_BITS  write word
//  rsp_valid  out  1          one-cycle completion pulse (no backpressure)
//  rsp_rdata  out  WORD_BITS  read word; held until next read completes
//  rsp_err    out  1          write-verify mismatch, valid with rsp_valid
//  mib        out  1          serial bit into the store
//  mob        in   NTANKS     serial bits out of each tank
//  tank_clr   out  NTANKS     one-hot: erase circulating bit this cycle
//  tank_in    out  NTANKS     one-hot: recirculate mib instead
//  tank_out   out  NTANKS     one-hot: route mob[t] to this block
//  circ_pos   out  10         current circulation position 0..TANK_BITS-1
// BEHAVIOUR
//  - Reset: circ_pos=0, state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mib=0, all strobes 0.
//  - Reset applies asynchronously at any point, including mid-transfer; a partial write is abandoned and no rsp is issued.
//  - circ_pos: +1 every cycle; wraps TANK_BITS-1 -> 0. Never stalls.
//  - base = word*WORD_BITS; bit k of the word is at circ_pos == base+k.
//  - FSM IDLE -> WAIT on accept; latches write, tank and word, plus wdata.
//  - WAIT -> XFER on the first cycle with circ_pos==base strictly after the accept cycle.
//    Accepting while circ_pos==base waits a full circulation. Wait is 1..TANK_BITS cycles.
//  - XFER: WORD_BITS cycles with bit index k = circ_pos-base.
//    Write: tank_clr[t]=tank_in[t]=1 and mib=wdata[k], all registered-aligned to circ_pos.
//    Read: tank_out[t]=1; mob[t] is sampled into rdata[k] at the end of that cycle.
//  - XFER -> DONE after k==WORD_BITS-1. DONE lasts 1 cycle with rsp_valid=1 (rdata updated on reads), then -> IDLE.
//  - Strobes and mib are 0 outside XFER/VERIFY; mib=0 on reads.
//  - Word 31 ends at circ_pos 575; DONE then coincides with circ_pos 0 (wrap).
//  - req_valid is ignored outside IDLE. Tank index >= NTANKS is not possible at the defaults.
// CONFIGURATION
//  STORE_WRITE_VERIFY_EN defined:
//    After a write XFER -> VWAIT -> VERIFY, a read of the same word on the next pass (VWAIT ends when circ_pos==base).
//    rsp_err=1 in DONE if any read-back bit differs from wdata.
//    Write latency grows by TANK_BITS cycles.
//  Undefined: no VWAIT/VERIFY states; rsp_err is tied 0.
// TESTING
//  1 Assert rst mid-cycle -> immediately all strobes=0, mib=0, rsp_valid=0. After release circ_pos counts 0,1,2...
//  2 Write 0x2AAAA to tank1/word3, accepted at circ_pos 0 -> tank_in[1]=tank_clr[1]=1 for circ_pos 54..71.
//    mib=0,1,0,1..., LSB first; rsp_valid at circ_pos 72.
//  3 Read tank1/word3 with a behavioural 4x576 tank model -> tank_out[1] for circ_pos 54..71; rsp_rdata=0x2AAAA.
//  4 Read word31 accepted at circ_pos 560 -> XFER at circ_pos 558..575 on the next pass; rsp_valid at circ_pos 0.
//  5 Request accepted at circ_pos==base (word3, pos 54) -> XFER starts 576 cycles later. req_valid held in XFER is not re-accepted.
//  6 With STORE_WRITE_VERIFY_EN, model flips bit5 on verify -> rsp_err=1 one pass later. Without the flip, rsp_err=0.

Source files
------------

// File: rtl/store_access_ctrl.sv
// Bit-serial word access sequencer for one group of mercury delay-line tanks.
// Define STORE_WRITE_VERIFY_EN to read back every write on the next pass and flag mismatches.
module store_access_ctrl #(
  parameter int NTANKS    = 4,
  parameter int WORDS     = 32,
  parameter int WORD_BITS = 18,
  parameter int TANK_BITS = WORDS * WORD_BITS,
  parameter int ADDR_W    = $clog2(NTANKS) + $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_BITS-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mib,
  input  logic [NTANKS-1:0]    mob,
  output logic [NTANKS-1:0]    tank_clr,
  output logic [NTANKS-1:0]    tank_in,
  output logic [NTANKS-1:0]    tank_out,
  output logic [9:0]           circ_pos
);

  localparam int TW = $clog2(NTANKS);
  localparam int WW = $clog2(WORDS);
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [9:0]    LAST_POS = 10'(TANK_BITS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
`ifdef STORE_WRITE_VERIFY_EN
    S_VWAIT,
    S_VERIFY,
`endif
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [9:0]           circ_pos_q, circ_pos_d;
  logic                 write_q, write_d;
  logic [TW-1:0]        tank_q, tank_d;
  logic [WW-1:0]        word_q, word_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_BITS-1:0] acc_q, acc_d;
  logic [WORD_BITS-1:0] rdata_q, rdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 mib_q, mib_d;
  logic [NTANKS-1:0]    clr_q, clr_d;
  logic [NTANKS-1:0]    in_q, in_d;
  logic [NTANKS-1:0]    out_q, out_d;
  logic [9:0]           base, req_base;
  logic                 sample_bit;
`ifdef STORE_WRITE_VERIFY_EN
  logic                 err_q, err_d;
  logic                 rsp_err_q, rsp_err_d;
`endif

  function automatic logic [9:0] word_base(input logic [WW-1:0] w);
    return 10'(w) * 10'(WORD_BITS);
  endfunction

  assign base       = word_base(word_q);
  assign req_base   = word_base(req_addr[WW-1:0]);
  assign sample_bit = mob[tank_q];
  assign circ_pos_d = (circ_pos_q == LAST_POS) ? 10'd0 : circ_pos_q + 10'd1;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    tank_d      = tank_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    bit_d       = bit_q;
    acc_d       = acc_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
`ifdef STORE_WRITE_VERIFY_EN
    err_d       = err_q;
    rsp_err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          tank_d  = req_addr[ADDR_W-1:WW];
          word_d  = req_addr[WW-1:0];
          wdata_d = req_wdata;
          bit_d   = '0;
`ifdef STORE_WRITE_VERIFY_EN
          err_d   = 1'b0;
`endif
          // Accepting one slot before the word arrives still catches it on this pass
          state_d = (circ_pos_d == req_base) ? S_XFER : S_WAIT;
        end
      end
      S_WAIT: begin
        if (circ_pos_d == base) state_d = S_XFER;
      end
      S_XFER: begin
        if (!write_q) acc_d[bit_q] = sample_bit;
        if (bit_q == LAST_BIT) begin
          bit_d = '0;
`ifdef STORE_WRITE_VERIFY_EN
          if (write_q) begin
            state_d = S_VWAIT;
          end else begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rdata_d     = acc_d;
          end
`else
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          if (!write_q) rdata_d = acc_d;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef STORE_WRITE_VERIFY_EN
      S_VWAIT: begin
        if (circ_pos_d == base) state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (sample_bit != wdata_q[bit_q]) err_d = 1'b1;
        if (bit_q == LAST_BIT) begin
          bit_d       = '0;
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_d;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are computed for the next slot so they line up with the registered circ_pos
    mib_d = 1'b0;
    clr_d = '0;
    in_d  = '0;
    out_d = '0;
    if (state_d == S_XFER) begin
      if (write_d) begin
        clr_d[tank_d] = 1'b1;
        in_d[tank_d]  = 1'b1;
        mib_d         = wdata_d[bit_d];
      end else begin
        out_d[tank_d] = 1'b1;
      end
    end
`ifdef STORE_WRITE_VERIFY_EN
    if (state_d == S_VERIFY) out_d[tank_d] = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      circ_pos_q  <= '0;
      write_q     <= 1'b0;
      tank_q      <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      bit_q       <= '0;
      acc_q       <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      mib_q       <= 1'b0;
      clr_q       <= '0;
      in_q        <= '0;
      out_q       <= '0;
`ifdef STORE_WRITE_VERIFY_EN
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      circ_pos_q  <= circ_pos_d;
      write_q     <= write_d;
      tank_q      <= tank_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      bit_q       <= bit_d;
      acc_q       <= acc_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      mib_q       <= mib_d;
      clr_q       <= clr_d;
      in_q        <= in_d;
      out_q       <= out_d;
`ifdef STORE_WRITE_VERIFY_EN
      err_q       <= err_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mib       = mib_q;
  assign tank_clr  = clr_q;
  assign tank_in   = in_q;
  assign tank_out  = out_q;
  assign circ_pos  = circ_pos_q;
`ifdef STORE_WRITE_VERIFY_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_store_access_ctrl.sv
// Scoreboard bench for store_access_ctrl: a behavioural 4x576 tank store drives mob,
// a word-level reference memory and slot timing predict every response and strobe.
module tb_store_access_ctrl;

  localparam int NT = 4;
  localparam int NW = 32;
  localparam int WB = 18;
  localparam int TB = NW * WB;
`ifdef STORE_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [6:0]  req_addr;
  logic [17:0] req_wdata;
  logic        rsp_valid, rsp_err, mib;
  logic [17:0] rsp_rdata;
  logic [3:0]  mob, tank_clr, tank_in, tank_out;
  logic [9:0]  circ_pos;

  store_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mib(mib), .mob(mob),
    .tank_clr(tank_clr), .tank_in(tank_in), .tank_out(tank_out),
    .circ_pos(circ_pos)
  );

  typedef struct {
    int          done_cyc;
    bit          is_read;
    logic [17:0] rdata;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks, n_fail;
  int          cyc;
  logic        store [NT][TB];
  logic [17:0] ref_mem [NT][NW];
  logic [17:0] exp_hold;
  bit          act_valid, act_write;
  int          act_acc, act_start, act_done, act_tank;
  logic [17:0] act_wdata;
  bit          flip_en;
  int          flip_tank, flip_pos;
  int          mc;
  logic [3:0]  e_clr, e_in, e_out;
  logic        e_mib, e_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index since reset; the common tank phase is this modulo the circulation length
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Tank store: reloaded from the reference words while in reset, otherwise recirculating
  always @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NT; t++)
        for (int p = 0; p < TB; p++)
          store[t][p] <= ref_mem[t][p / WB][p % WB];
    end else begin
      for (int t = 0; t < NT; t++) begin
        if (tank_in[t])       store[t][cyc % TB] <= mib;
        else if (tank_clr[t]) store[t][cyc % TB] <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NT; t++)
      mob[t] = store[t][cyc % TB] ^
               (flip_en && (t == flip_tank) && tank_out[t] && ((cyc % TB) == flip_pos));
  end

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on responses and checks per-slot strobes and counters
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_cycle", cyc, mon_e.done_cyc);
          if (mon_e.is_read) begin
            checkOutput("rsp_rdata", rsp_rdata, mon_e.rdata);
            exp_hold = mon_e.rdata;
          end
          checkOutput("rsp_err", rsp_err, mon_e.err);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].done_cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL rsp_timeout: got no rsp_valid, expected one at cycle %0d (now %0d)",
                 exp_q[0].done_cyc, cyc);
        void'(exp_q.pop_front());
      end

      checkOutput("circ_pos", circ_pos, cyc % TB);
      checkOutput("rdata_hold", rsp_rdata, exp_hold);

      mc      = cyc;
      e_clr   = '0;
      e_in    = '0;
      e_out   = '0;
      e_mib   = 1'b0;
      e_ready = 1'b1;
      if (act_valid) begin
        if (mc >= act_start && mc < act_start + WB) begin
          if (act_write) begin
            e_clr = 4'(1 << act_tank);
            e_in  = 4'(1 << act_tank);
            e_mib = act_wdata[mc - act_start];
          end else begin
            e_out = 4'(1 << act_tank);
          end
        end
        if (VERIFY && act_write && mc >= act_start + TB && mc < act_start + TB + WB)
          e_out = 4'(1 << act_tank);
        e_ready = !(mc > act_acc && mc <= act_done);
      end
      checkOutput("strobes", {req_ready, tank_clr, tank_in, tank_out, mib},
                  {e_ready, e_clr, e_in, e_out, e_mib});
    end
  end

  task automatic applyStimulus(input bit wr, input int tank, input int word,
                               input logic [17:0] wd, input int at_pos,
                               input bit hold, input bit flip);
    int   guard;
    int   base, w;
    exp_t e;
    guard = 0;
    while ((act_valid && cyc <= act_done) || (at_pos >= 0 && (cyc % TB) != at_pos)) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 4 * TB) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL accept_wait: got no issue slot, expected one within %0d cycles", 4 * TB);
        return;
      end
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = {2'(tank), 5'(word)};
    req_wdata = wd;
    base = word * WB;
    w    = (base - (cyc % TB) + TB) % TB;
    if (w == 0) w = TB;
    act_valid = 1'b1;
    act_write = wr;
    act_tank  = tank;
    act_wdata = wd;
    act_acc   = cyc;
    act_start = cyc + w;
    act_done  = act_start + WB + ((VERIFY && wr) ? TB : 0);
    e.done_cyc = act_done;
    e.is_read  = !wr;
    e.rdata    = ref_mem[tank][word];
    e.err      = VERIFY && wr && flip;
    if (wr) ref_mem[tank][word] = wd;
    if (flip) begin
      flip_en   = 1'b1;
      flip_tank = tank;
      flip_pos  = base + 5;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (hold) begin
      while (cyc < act_done) begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 3 * TB) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL idle_wait: got %0d pending responses, expected 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    act_valid = 1'b0;
    act_write = 1'b0;
    act_acc   = 0;
    act_start = 0;
    act_done  = 0;
    act_tank  = 0;
    act_wdata = '0;
    flip_en   = 1'b0;
    flip_tank = 0;
    flip_pos  = 0;
    exp_hold  = '0;
    for (int t = 0; t < NT; t++)
      for (int w = 0; w < NW; w++)
        ref_mem[t][w] = 18'($urandom);

    #12;
    checkOutput("reset_outputs", {tank_clr, tank_in, tank_out, mib, rsp_valid, rsp_err}, '0);
    checkOutput("reset_ready", req_ready, 1);
    checkOutput("reset_circ_pos", circ_pos, 0);
    checkOutput("reset_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] write 0x2AAAA to tank1/word3 at circ_pos 0");
    applyStimulus(1'b1, 1, 3, 18'h2AAAA, 0, 1'b0, 1'b0);
    waitIdle();
    $display("[TB] read back tank1/word3");
    applyStimulus(1'b0, 1, 3, 18'h0, -1, 1'b0, 1'b0);
    waitIdle();
    $display("[TB] read word31 accepted at circ_pos 560");
    applyStimulus(1'b0, 2, 31, 18'h0, 560, 1'b0, 1'b0);
    waitIdle();
    $display("[TB] write word31 accepted at circ_pos 557 (one slot early)");
    applyStimulus(1'b1, 3, 31, 18'h3FFFF, 557, 1'b0, 1'b0);
    waitIdle();
    $display("[TB] read accepted at circ_pos==base, req_valid held");
    applyStimulus(1'b0, 1, 3, 18'h0, 54, 1'b1, 1'b0);
    waitIdle();
`ifdef STORE_WRITE_VERIFY_EN
    $display("[TB] write with bit5 flipped on read-back");
    applyStimulus(1'b1, 2, 7, 18'h15A5A, -1, 1'b0, 1'b1);
    waitIdle();
    flip_en = 1'b0;
    applyStimulus(1'b1, 2, 7, 18'h0F0F0, -1, 1'b0, 1'b0);
    waitIdle();
`endif

    $display("[TB] reset in the middle of a write");
    applyStimulus(1'b1, 0, 10, ref_mem[0][10], -1, 1'b0, 1'b0);
    begin
      int guard;
      guard = 0;
      while (cyc < act_start + 5 && guard < 2 * TB) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_outputs", {tank_clr, tank_in, tank_out, mib, rsp_valid, rsp_err}, '0);
    checkOutput("midrst_ready", req_ready, 1);
    checkOutput("midrst_circ_pos", circ_pos, 0);
    exp_q.delete();
    act_valid = 1'b0;
    exp_hold  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 0, 10, 18'h0, -1, 1'b0, 1'b0);
    waitIdle();

    $display("[TB] randomized transactions");
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 8)) @(posedge clk);
      #1;
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, NT - 1)),
                    int'($urandom_range(0, NW - 1)), 18'($urandom), -1, 1'b0, 1'b0);
      waitIdle();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
